// File: rtl/voice_allocator_pkg.sv
// rtl/voice_allocator_pkg.sv - shared states, waveform codes and pitch macro for voice_allocator
// Purpose : FSM state type, waveform select codes and the MIDI note -> phase
//           increment mapping used by the pitch ROM.
// Ports   : none (package).
`ifndef VOICE_ALLOCATOR_MIDI_NOTE
`define VOICE_ALLOCATOR_MIDI_NOTE
`define MIDI_NOTE(n) voice_allocator_pkg::midi_note_incr(7'(n))
`endif

package voice_allocator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_APPLY = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam logic [3:0] WAVE_SINE   = 4'b0001;
   localparam logic [3:0] WAVE_SQUARE = 4'b0010;
   localparam logic [3:0] WAVE_SAW    = 4'b0100;
   localparam logic [3:0] WAVE_TRI    = 4'b1000;

   // 16-bit phase increment at a 48 kHz sample clock. The top octave
   // (notes 120..131) is tabulated; lower octaves are exact halvings.
   function automatic logic [15:0] midi_note_incr(input logic [6:0] note);
      logic [15:0] top;
      int          octave;
      int          semi;
      octave = int'(note) / 12;
      semi   = int'(note) % 12;
      case (semi)
         0:       top = 16'd11431;
         1:       top = 16'd12110;
         2:       top = 16'd12830;
         3:       top = 16'd13593;
         4:       top = 16'd14402;
         5:       top = 16'd15258;
         6:       top = 16'd16165;
         7:       top = 16'd17126;
         8:       top = 16'd18145;
         9:       top = 16'd19224;
         10:      top = 16'd20367;
         default: top = 16'd21578;
      endcase
      return top >> (10 - octave);
   endfunction

endpackage

// File: rtl/voice_allocator_note_pitch_rom.sv
// rtl/voice_allocator_note_pitch_rom.sv - 128-entry registered note pitch ROM
// Purpose : maps a MIDI note number to its phase increment, 1-cycle latency.
// Ports   : i_clk  - system clock
//           i_addr - MIDI note number
//           o_data - phase increment of the note addressed on the previous cycle
module voice_allocator_note_pitch_rom
   import voice_allocator_pkg::*;
#(
   parameter int PITCH_BITS = 16
) (
   input  logic                  i_clk,
   input  logic [6:0]            i_addr,
   output logic [PITCH_BITS-1:0] o_data
);

   logic [PITCH_BITS-1:0] w_table [128];
   logic [PITCH_BITS-1:0] r_data;

   for (genvar n = 0; n < 128; n++) begin : g_rom
      assign w_table[n] = PITCH_BITS'(`MIDI_NOTE(n));
   end

   always_ff @(posedge i_clk) begin
      r_data <= w_table[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note scheduler driving a bank of voices
// Purpose : accepts note-on/off events, allocates voices (match, LRU free,
//           else steal LRU) and drives per-voice gate, pitch and waveform.
// Ports   : i_clk, i_rst_n            - clock, async active-low reset
//           i_evt_valid/o_evt_ready   - event handshake
//           i_evt_on/i_evt_note/i_evt_wave - event fields
//           i_panic                   - all-notes-off (level)
//           o_gate                    - per-voice gate
//           o_pitch_incr              - voice v at [v*PITCH_BITS +: PITCH_BITS]
//           o_voice_select            - voice v at [v*4 +: 4]
//           o_steal                   - 1-cycle pulse when a held voice is stolen
module voice_allocator
   import voice_allocator_pkg::*;
#(
   parameter int NUM_VOICES    = 4,
   parameter int PITCH_BITS    = 16,
   parameter int RETRIG_CYCLES = 512
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_evt_valid,
   output logic                             o_evt_ready,
   input  logic                             i_evt_on,
   input  logic [6:0]                       i_evt_note,
   input  logic [3:0]                       i_evt_wave,
   input  logic                             i_panic,
   output logic [NUM_VOICES-1:0]            o_gate,
   output logic [NUM_VOICES*PITCH_BITS-1:0] o_pitch_incr,
   output logic [NUM_VOICES*4-1:0]          o_voice_select,
   output logic                             o_steal
);

   localparam int            IW       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int            CW       = $clog2(RETRIG_CYCLES + 1);
   localparam logic [IW-1:0] LAST_V   = IW'(NUM_VOICES - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(RETRIG_CYCLES);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_accept;
   logic [IW-1:0]         r_scan_idx;
   logic                  r_on;
   logic [6:0]            r_note;
   logic [3:0]            r_wave;
   logic [6:0]            r_tag   [NUM_VOICES];
   logic [IW-1:0]         r_rank  [NUM_VOICES];
   logic [PITCH_BITS-1:0] r_pitch [NUM_VOICES];
   logic [3:0]            r_vsel  [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_gate;
   logic                  r_steal;
   logic                  r_match_found;
   logic                  r_free_found;
   logic [IW-1:0]         r_match_idx;
   logic [IW-1:0]         r_free_idx;
   logic [IW-1:0]         r_lru_idx;
   logic [IW-1:0]         r_target;
   logic [CW-1:0]         r_gap_cnt;
   logic [6:0]            w_rom_addr;
   logic [PITCH_BITS-1:0] w_rom_pitch;
   logic [IW-1:0]         w_target;
   logic                  w_target_busy;
   logic                  w_is_steal;

   assign o_evt_ready = (r_state == ST_IDLE) && !i_panic;
   assign w_accept    = i_evt_valid && o_evt_ready;

   // The ROM address follows the live input while idle so the lookup is
   // issued on the accept cycle, then holds the latched note.
   assign w_rom_addr = (r_state == ST_IDLE) ? i_evt_note : r_note;

   voice_allocator_note_pitch_rom #(
      .PITCH_BITS (PITCH_BITS)
   ) u_note_pitch_rom (
      .i_clk  (i_clk),
      .i_addr (w_rom_addr),
      .o_data (w_rom_pitch)
   );

   // Note-on target priority: matching held voice, LRU free voice, LRU overall.
   always_comb begin
      w_target   = r_lru_idx;
      w_is_steal = 1'b1;
      if (r_match_found) begin
         w_target   = r_match_idx;
         w_is_steal = 1'b0;
      end else if (r_free_found) begin
         w_target   = r_free_idx;
         w_is_steal = 1'b0;
      end
      w_target_busy = r_gate[w_target];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_panic) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = ST_SCAN;
            ST_SCAN:  if (r_scan_idx == LAST_V) w_state_nxt = ST_APPLY;
            ST_APPLY: w_state_nxt = (r_on && w_target_busy) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (r_gap_cnt == CW'(1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scan_idx    <= '0;
         r_on          <= 1'b0;
         r_note        <= '0;
         r_wave        <= '0;
         r_gate        <= '0;
         r_steal       <= 1'b0;
         r_match_found <= 1'b0;
         r_free_found  <= 1'b0;
         r_match_idx   <= '0;
         r_free_idx    <= '0;
         r_lru_idx     <= '0;
         r_target      <= '0;
         r_gap_cnt     <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_tag[v]   <= '0;
            r_rank[v]  <= IW'(v);
            r_pitch[v] <= '0;
            r_vsel[v]  <= '0;
         end
      end else begin
         r_steal <= 1'b0;
         if (i_panic) begin
            r_gate <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_accept) begin
                     r_on          <= i_evt_on;
                     r_note        <= i_evt_note;
                     r_wave        <= i_evt_wave;
                     r_scan_idx    <= '0;
                     r_match_found <= 1'b0;
                     r_free_found  <= 1'b0;
                  end
               end
               ST_SCAN: begin
                  r_scan_idx <= r_scan_idx + 1'b1;
                  if (r_gate[r_scan_idx] && (r_tag[r_scan_idx] == r_note)) begin
                     r_match_found <= 1'b1;
                     r_match_idx   <= r_scan_idx;
                  end
                  if (!r_gate[r_scan_idx] &&
                      (!r_free_found || (r_rank[r_scan_idx] < r_rank[r_free_idx]))) begin
                     r_free_found <= 1'b1;
                     r_free_idx   <= r_scan_idx;
                  end
                  // Ranks are a permutation, so rank 0 is the overall LRU voice.
                  if (r_rank[r_scan_idx] == '0) r_lru_idx <= r_scan_idx;
               end
               ST_APPLY: begin
                  if (r_on) begin
                     r_tag[w_target]   <= r_note;
                     r_pitch[w_target] <= w_rom_pitch;
                     r_vsel[w_target]  <= r_wave;
                     r_target          <= w_target;
                     r_steal           <= w_is_steal;
                     for (int v = 0; v < NUM_VOICES; v++) begin
                        if (IW'(v) == w_target)
                           r_rank[v] <= LAST_V;
                        else if (r_rank[v] > r_rank[w_target])
                           r_rank[v] <= r_rank[v] - 1'b1;
                     end
                     // A sounding voice is dropped for a gap so the envelope restarts.
                     if (w_target_busy) begin
                        r_gate[w_target] <= 1'b0;
                        r_gap_cnt        <= GAP_LOAD;
                     end else begin
                        r_gate[w_target] <= 1'b1;
                     end
                  end else if (r_match_found) begin
                     r_gate[r_match_idx] <= 1'b0;
                  end
               end
               ST_GAP: begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
                  if (r_gap_cnt == CW'(1)) r_gate[r_target] <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      o_pitch_incr   = '0;
      o_voice_select = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         o_pitch_incr[v*PITCH_BITS +: PITCH_BITS] = r_pitch[v];
         o_voice_select[v*4 +: 4]                 = r_vsel[v];
      end
   end

   assign o_gate  = r_gate;
   assign o_steal = r_steal;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - self-checking bench for voice_allocator
`ifndef VOICE_ALLOCATOR_MIDI_NOTE
`define VOICE_ALLOCATOR_MIDI_NOTE
`define MIDI_NOTE(n) voice_allocator_pkg::midi_note_incr(7'(n))
`endif

module tb_voice_allocator;
   import voice_allocator_pkg::*;

   localparam int N  = 4;
   localparam int PB = 16;
   localparam int RC = 512;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            evt_valid = 1'b0;
   logic            evt_ready;
   logic            evt_on = 1'b0;
   logic [6:0]      evt_note = '0;
   logic [3:0]      evt_wave = '0;
   logic            panic = 1'b0;
   logic [N-1:0]    gate;
   logic [N*PB-1:0] pitch_incr;
   logic [N*4-1:0]  voice_select;
   logic            steal;

   int n_checks  = 0;
   int n_pass    = 0;
   int steal_cnt = 0;

   // Reference model: per-voice state plus an LRU list (front = least recent).
   bit          m_gate  [N];
   int          m_tag   [N];
   logic [PB-1:0] m_pitch [N];
   logic [3:0]  m_vsel  [N];
   int          m_lru   [$];

   voice_allocator #(
      .NUM_VOICES    (N),
      .PITCH_BITS    (PB),
      .RETRIG_CYCLES (RC)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_evt_valid    (evt_valid),
      .o_evt_ready    (evt_ready),
      .i_evt_on       (evt_on),
      .i_evt_note     (evt_note),
      .i_evt_wave     (evt_wave),
      .i_panic        (panic),
      .o_gate         (gate),
      .o_pitch_incr   (pitch_incr),
      .o_voice_select (voice_select),
      .o_steal        (steal)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (steal === 1'b1) steal_cnt++;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [N-1:0] m_gate_vec();
      logic [N-1:0] g;
      for (int v = 0; v < N; v++) g[v] = m_gate[v];
      return g;
   endfunction

   task automatic model_reset();
      m_lru.delete();
      for (int v = 0; v < N; v++) begin
         m_gate[v]  = 1'b0;
         m_tag[v]   = 0;
         m_pitch[v] = '0;
         m_vsel[v]  = '0;
         m_lru.push_back(v);
      end
   endtask

   task automatic model_touch(input int tgt);
      for (int i = 0; i < m_lru.size(); i++) begin
         if (m_lru[i] == tgt) begin
            m_lru.delete(i);
            break;
         end
      end
      m_lru.push_back(tgt);
   endtask

   task automatic check_outputs(input string tag);
      logic [N*PB-1:0] ep;
      logic [N*4-1:0]  ev;
      for (int v = 0; v < N; v++) begin
         ep[v*PB +: PB] = m_pitch[v];
         ev[v*4 +: 4]   = m_vsel[v];
      end
      check_eq({tag, "_gate"}, gate, m_gate_vec());
      check_eq({tag, "_pitch"}, pitch_incr, ep);
      check_eq({tag, "_vsel"}, voice_select, ev);
   endtask

   // Presents one event and returns right after the accepting edge (+1).
   task automatic send(input bit on, input int note, input logic [3:0] wave, output int waited);
      @(negedge clk);
      evt_valid = 1'b1;
      evt_on    = on;
      evt_note  = 7'(note);
      evt_wave  = wave;
      waited    = 0;
      while (evt_ready !== 1'b1 && waited < 2000) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 2000) check_eq("handshake_timeout", 0, 1);
      @(posedge clk);
      #1;
      evt_valid = 1'b0;
   endtask

   // Decides the target from the model rules (match, oldest free, oldest overall).
   task automatic model_pick(input bit on, input int note, output int tgt, output bit busy,
                             output bit stl);
      tgt  = -1;
      busy = 1'b0;
      stl  = 1'b0;
      for (int v = 0; v < N; v++) if (m_gate[v] && m_tag[v] == note) tgt = v;
      if (on) begin
         if (tgt < 0) begin
            foreach (m_lru[i]) if (tgt < 0 && !m_gate[m_lru[i]]) tgt = m_lru[i];
         end
         if (tgt < 0) begin
            tgt = m_lru[0];
            stl = 1'b1;
         end
         busy = m_gate[tgt];
      end
   endtask

   task automatic model_apply(input bit on, input int note, input logic [3:0] wave,
                              input int tgt, input bit busy);
      if (on) begin
         m_tag[tgt]   = note;
         m_pitch[tgt] = `MIDI_NOTE(note);
         m_vsel[tgt]  = wave;
         m_gate[tgt]  = !busy;
         model_touch(tgt);
      end else if (tgt >= 0) begin
         m_gate[tgt] = 1'b0;
      end
   endtask

   task automatic do_event(input bit on, input int note, input logic [3:0] wave, output int waited);
      int           tgt;
      int           s0;
      bit           busy;
      bit           stl;
      logic [N-1:0] pre;
      model_pick(on, note, tgt, busy, stl);
      pre = m_gate_vec();
      s0  = steal_cnt;
      send(on, note, wave, waited);
      repeat (N) @(posedge clk);
      #1;
      check_eq("gate_before_apply", gate, pre);
      @(posedge clk);
      #1;
      model_apply(on, note, wave, tgt, busy);
      check_eq("gate_at_apply", gate, m_gate_vec());
      if (on && busy) begin
         repeat (RC - 1) @(posedge clk);
         #1;
         check_eq("gap_still_low", gate, m_gate_vec());
         @(posedge clk);
         #1;
         m_gate[tgt] = 1'b1;
         check_eq("gap_regate", gate, m_gate_vec());
      end
      @(negedge clk);
      check_eq("steal_pulses", steal_cnt - s0, 64'(stl));
      check_outputs("post_event");
      check_eq("ready_after_event", evt_ready, 1);
   endtask

   initial begin
      int  w;
      int  tgt;
      bit  busy;
      bit  stl;

      model_reset();
      #1;
      check_eq("ready_in_reset", evt_ready, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_outputs("reset");
      check_eq("reset_steal", steal, 0);

      // Single note-on to an idle bank lands on voice 0.
      do_event(1'b1, 60, WAVE_SQUARE, w);
      check_eq("t1_gate", gate, 4'b0001);
      check_eq("t1_pitch", pitch_incr[15:0], `MIDI_NOTE(60));
      check_eq("t1_vsel", voice_select[3:0], WAVE_SQUARE);

      // Chord then release of the second note.
      do_event(1'b1, 64, WAVE_SINE, w);
      do_event(1'b1, 67, WAVE_SAW, w);
      do_event(1'b1, 71, WAVE_TRI, w);
      do_event(1'b0, 64, WAVE_SINE, w);
      check_eq("t2_gate", gate, 4'b1101);
      check_eq("t2_pitch_v1", pitch_incr[31:16], `MIDI_NOTE(64));

      // Refill, then a fifth note steals the oldest (voice 0).
      do_event(1'b1, 64, WAVE_SINE, w);
      do_event(1'b1, 72, WAVE_SAW, w);
      check_eq("t3_pitch_v0", pitch_incr[15:0], `MIDI_NOTE(72));

      // Same note again retriggers its voice without a steal.
      do_event(1'b1, 72, WAVE_SQUARE, w);

      // Note-off for a note never played is consumed at once.
      do_event(1'b0, 50, WAVE_SINE, w);
      check_eq("t5_handshake_wait", w, 0);

      // Panic during a retrigger gap.
      model_pick(1'b1, 67, tgt, busy, stl);
      send(1'b1, 67, WAVE_TRI, w);
      repeat (N + 1) @(posedge clk);
      #1;
      model_apply(1'b1, 67, WAVE_TRI, tgt, busy);
      check_eq("t6_gap_gate", gate, m_gate_vec());
      @(negedge clk);
      evt_valid = 1'b1;
      evt_on    = 1'b1;
      evt_note  = 7'd40;
      evt_wave  = WAVE_SINE;
      repeat (5) @(negedge clk);
      check_eq("t6_ready_in_gap", evt_ready, 0);
      evt_valid = 1'b0;
      panic     = 1'b1;
      @(posedge clk);
      #1;
      for (int v = 0; v < N; v++) m_gate[v] = 1'b0;
      check_eq("t6_panic_gate", gate, 4'b0000);
      check_eq("t6_ready_panic", evt_ready, 0);
      @(negedge clk);
      panic = 1'b0;
      #1;
      check_eq("t6_ready_after", evt_ready, 1);
      repeat (RC + 20) @(negedge clk);
      check_outputs("t6_after_gap_window");

      // Rebuild some held voices, then reset in the middle of an event.
      do_event(1'b1, 61, WAVE_SAW, w);
      do_event(1'b1, 62, WAVE_SINE, w);
      send(1'b1, 63, WAVE_TRI, w);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      check_eq("async_reset_steal", steal, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (N + 3) @(negedge clk);
      check_outputs("after_reset");

      // Randomized traffic over a narrow note range to force matches and steals.
      for (int i = 0; i < 40; i++) begin
         bit          on;
         int          note;
         logic [3:0]  wave;
         on   = ($urandom_range(0, 9) < 6);
         note = 60 + $urandom_range(0, 7);
         wave = 4'b0001 << $urandom_range(0, 3);
         do_event(on, note, wave, w);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
